// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
//   Shared definitions for the GPIO bank: register address map and the
//   width of the register bus address.
package gpio_bank_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DOUT     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DIN      = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_RSVD     = 3'd7;

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if
//   Simple register bus used to access the GPIO bank.
//   wr_en  : write strobe, data in wdata is written to addr
//   rd_en  : read strobe, rdata/rvalid answer one cycle later
//   addr   : register address
//   wdata  : write data, one bit per channel
//   rdata  : read data, valid while rvalid = 1
//   rvalid : one-cycle read acknowledge
//   The master modport belongs to the bus driver, slave to the GPIO bank.
interface gpio_bank_if #(
    parameter int NCH = 8
);
    import gpio_bank_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [NCH-1:0]    wdata;
    logic [NCH-1:0]    rdata;
    logic              rvalid;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rvalid
    );

endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   One GPIO input channel: two-flop synchroniser, debounce filter producing
//   a stable level, and single-cycle rise/fall pulses on that stable level.
//   clk   : clock
//   rst   : synchronous active-high reset
//   pad   : raw asynchronous pad input
//   level : debounced (stable) input level
//   rise  : one-cycle pulse when level goes 0 -> 1
//   fall  : one-cycle pulse when level goes 1 -> 0
module gpio_debounce #(
    parameter int DEB_W   = 8,
    parameter int DEB_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_a;
    logic sync_b;
    logic prev;

    // Two-flop synchroniser bringing the asynchronous pad into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pad;
            sync_b <= sync_a;
        end
    end

    generate
        if (DEB_CNT == 0) begin : g_bypass
            assign level = sync_b;
        end else begin : g_filter
            localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CNT - 1);

            logic [DEB_W-1:0] cnt;
            logic             stable;

            // The counter runs only while the synchronised input disagrees with
            // the stable level; the level flips once the count reaches LAST,
            // i.e. after DEB_CNT consecutive cycles at the new level. Any return
            // to the old level clears the count, so short glitches are lost.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync_b == stable) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync_b;
                    cnt    <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign level = stable;
        end
    endgenerate

    // Previous stable level for edge detection. Reset to 0 together with the
    // stable level so that returning to 0 on reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank
//   Parametrised bidirectional GPIO bank with per-channel debounced inputs,
//   edge detection and sticky interrupt status, accessed over a simple
//   register bus.
//   clk    : clock, all logic on the rising edge
//   rst    : synchronous active-high reset
//   pad_i  : raw pad inputs
//   pad_o  : pad output data (DOUT register)
//   pad_oe : pad output enables, 1 = drive (DIR register)
//   irq    : registered OR of enabled interrupt status bits
//   bus    : register bus (slave side)
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int DEB_W   = 8,
    parameter int DEB_CNT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  pad_i,
    output logic [NCH-1:0]  pad_o,
    output logic [NCH-1:0]  pad_oe,
    output logic            irq,
    gpio_bank_if.slave      bus
);

    logic [NCH-1:0] dout;
    logic [NCH-1:0] dir;
    logic [NCH-1:0] irq_en;
    logic [NCH-1:0] irq_stat;
    logic [NCH-1:0] rise_en;
    logic [NCH-1:0] fall_en;

    logic [NCH-1:0] din;
    logic [NCH-1:0] rise_vec;
    logic [NCH-1:0] fall_vec;
    logic [NCH-1:0] stat_set;
    logic [NCH-1:0] stat_clr;
    logic [NCH-1:0] rd_mux;

    // One debounce/edge channel per pad.
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            gpio_debounce #(
                .DEB_W   (DEB_W),
                .DEB_CNT (DEB_CNT)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .pad   (pad_i[i]),
                .level (din[i]),
                .rise  (rise_vec[i]),
                .fall  (fall_vec[i])
            );
        end
    endgenerate

    // Gated edges set status bits; a W1C write to IRQ_STAT clears them.
    // The set term is OR-ed in after the clear so a same-cycle edge wins.
    assign stat_set = (rise_vec & rise_en) | (fall_vec & fall_en);
    assign stat_clr = (bus.wr_en && bus.addr == ADDR_IRQ_STAT) ? bus.wdata : '0;

    // Register writes. DIN and the reserved address have no storage, so
    // writes to them fall through the case and are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            dir      <= '0;
            irq_en   <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_stat <= '0;
        end else begin
            if (bus.wr_en) begin
                case (bus.addr)
                    ADDR_DOUT:    dout    <= bus.wdata;
                    ADDR_DIR:     dir     <= bus.wdata;
                    ADDR_IRQ_EN:  irq_en  <= bus.wdata;
                    ADDR_RISE_EN: rise_en <= bus.wdata;
                    ADDR_FALL_EN: fall_en <= bus.wdata;
                    default:      ;
                endcase
            end
            irq_stat <= (irq_stat & ~stat_clr) | stat_set;
        end
    end

    // Read mux on the current (pre-write) register values, so a read and a
    // write to the same address in one cycle return the old contents.
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_DOUT:     rd_mux = dout;
            ADDR_DIR:      rd_mux = dir;
            ADDR_DIN:      rd_mux = din;
            ADDR_IRQ_EN:   rd_mux = irq_en;
            ADDR_IRQ_STAT: rd_mux = irq_stat;
            ADDR_RISE_EN:  rd_mux = rise_en;
            ADDR_FALL_EN:  rd_mux = fall_en;
            ADDR_RSVD:     rd_mux = '0;
            default:       rd_mux = '0;
        endcase
    end

    // Registered read response and interrupt output. rdata is held at zero
    // outside of a read acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            bus.rvalid <= bus.rd_en;
            bus.rdata  <= bus.rd_en ? rd_mux : '0;
            irq        <= |(irq_stat & irq_en);
        end
    end

    assign pad_o  = dout;
    assign pad_oe = dir;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank
//   Self-checking bench for gpio_bank with NCH=8, DEB_W=8, DEB_CNT=16.
//   Register accesses go through the bus interface; expected values are
//   hand-computed constants.
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    localparam int NCH     = 8;
    localparam int DEB_CNT = 16;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] pad_i;
    logic [NCH-1:0] pad_o;
    logic [NCH-1:0] pad_oe;
    logic           irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_bank_if #(.NCH(NCH)) bus ();

    gpio_bank #(
        .NCH     (NCH),
        .DEB_W   (8),
        .DEB_CNT (DEB_CNT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (pad_i),
        .pad_o  (pad_o),
        .pad_oe (pad_oe),
        .irq    (irq),
        .bus    (bus.slave)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound on total run time in case something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[8];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Read with a check that rvalid is raised exactly one cycle after rd_en.
    task automatic busRead(input string name, input logic [2:0] a,
                           input logic [7:0] exp);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checkOutput({name, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        checkOutput(name, 32'(bus.rdata), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{ADDR_DIR,      8'hF0, 8'hF0, "rd_dir"};
        vecs[1] = '{ADDR_DOUT,     8'hA5, 8'hA5, "rd_dout"};
        vecs[2] = '{ADDR_IRQ_EN,   8'h3C, 8'h3C, "rd_irq_en"};
        vecs[3] = '{ADDR_RISE_EN,  8'h5A, 8'h5A, "rd_rise_en"};
        vecs[4] = '{ADDR_FALL_EN,  8'h81, 8'h81, "rd_fall_en"};
        vecs[5] = '{ADDR_DIN,      8'hFF, 8'h00, "rd_din_ro"};
        vecs[6] = '{ADDR_RSVD,     8'hFF, 8'h00, "rd_rsvd"};
        vecs[7] = '{ADDR_IRQ_STAT, 8'hFF, 8'h00, "rd_stat_w1c"};

        rst       = 1'b1;
        pad_i     = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rst_pad_oe", 32'(pad_oe), 32'h0);
        checkOutput("rst_pad_o",  32'(pad_o),  32'h0);
        checkOutput("rst_irq",    32'(irq),    32'h0);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 32'h0);
        busRead("rst_din", ADDR_DIN, 8'h00);
        tick();
        checkOutput("rvalid_pulse", 32'(bus.rvalid), 32'h0);

        // Register write / read-back table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata);
            busRead(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        checkOutput("pad_oe_dir", 32'(pad_oe), 32'hF0);
        checkOutput("pad_o_dout", 32'(pad_o),  32'hA5);

        // Read and write to the same address in one cycle returns old data.
        bus.addr  = ADDR_DOUT;
        bus.wdata = 8'h3C;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        checkOutput("rw_same_old", 32'(bus.rdata), 32'hA5);
        checkOutput("rw_same_pad", 32'(pad_o), 32'h3C);

        applyStimulus(ADDR_IRQ_EN, 8'h00);
        applyStimulus(ADDR_RISE_EN, 8'h00);
        applyStimulus(ADDR_FALL_EN, 8'h00);

        // Debounce latency: DIN[0] follows exactly 2+DEB_CNT edges later.
        pad_i[0] = 1'b1;
        repeat (2 + DEB_CNT - 1) tick();
        busRead("deb_before", ADDR_DIN, 8'h00);
        busRead("deb_after",  ADDR_DIN, 8'h01);

        // A 10-cycle glitch must not reach DIN.
        pad_i[0] = 1'b0;
        repeat (10) tick();
        pad_i[0] = 1'b1;
        repeat (30) tick();
        busRead("deb_glitch", ADDR_DIN, 8'h01);

        // Rising edge on ch0 sets status and irq; W1C clears; fall is not enabled.
        pad_i[0] = 1'b0;
        repeat (25) tick();
        busRead("fall_dis_din", ADDR_DIN, 8'h00);
        applyStimulus(ADDR_RISE_EN, 8'h01);
        applyStimulus(ADDR_IRQ_EN, 8'h01);
        busRead("no_stat_yet", ADDR_IRQ_STAT, 8'h00);
        pad_i[0] = 1'b1;
        repeat (25) tick();
        checkOutput("irq_set", 32'(irq), 32'h1);
        busRead("stat_rise", ADDR_IRQ_STAT, 8'h01);
        applyStimulus(ADDR_IRQ_STAT, 8'h01);
        tick();
        checkOutput("irq_clr", 32'(irq), 32'h0);
        busRead("stat_clr", ADDR_IRQ_STAT, 8'h00);
        pad_i[0] = 1'b0;
        repeat (25) tick();
        busRead("stat_fall_dis", ADDR_IRQ_STAT, 8'h00);
        checkOutput("irq_fall_dis", 32'(irq), 32'h0);

        // Same-cycle W1C and new edge on ch3: set wins.
        applyStimulus(ADDR_RISE_EN, 8'h08);
        applyStimulus(ADDR_FALL_EN, 8'h08);
        pad_i[3] = 1'b1;
        repeat (25) tick();
        busRead("ch3_rise", ADDR_IRQ_STAT, 8'h08);
        pad_i[3] = 1'b0;
        repeat (2 + DEB_CNT) tick();
        applyStimulus(ADDR_IRQ_STAT, 8'h08);
        busRead("set_wins", ADDR_IRQ_STAT, 8'h08);
        applyStimulus(ADDR_IRQ_STAT, 8'h08);
        busRead("ch3_w1c", ADDR_IRQ_STAT, 8'h00);

        // Reset mid-count on ch1 with a pending interrupt.
        applyStimulus(ADDR_IRQ_EN, 8'h08);
        applyStimulus(ADDR_DOUT, 8'hFF);
        applyStimulus(ADDR_DIR, 8'hFF);
        pad_i[3] = 1'b1;
        repeat (25) tick();
        checkOutput("pre_rst_irq", 32'(irq), 32'h1);
        pad_i[1] = 1'b1;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_pad_o",  32'(pad_o),  32'h0);
        checkOutput("mid_rst_pad_oe", 32'(pad_oe), 32'h0);
        checkOutput("mid_rst_irq",    32'(irq),    32'h0);
        rst = 1'b0;
        repeat (2 + DEB_CNT - 1) tick();
        busRead("post_rst_before", ADDR_DIN, 8'h00);
        busRead("post_rst_after",  ADDR_DIN, 8'h0A);
        busRead("post_rst_stat",   ADDR_IRQ_STAT, 8'h00);
        checkOutput("post_rst_irq", 32'(irq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
